// File: rtl/pixel_pkg.sv
// Shared AHB encodings and reader FSM state type for the AHB pixel reader.
package pixel_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } reader_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous power-of-two pixel FIFO with occupancy count and flush.
module pixel_fifo #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // A full FIFO may still accept a push when the head leaves the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ahb_pixel_reader.sv
// AHB-Lite master streaming one frame of pixels into a valid/ready port.
// Define AHB_PIXEL_READER_ERR_EN to add HRESP abort handling and the err output.
module ahb_pixel_reader
  import pixel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int          NUM_PIXELS = 307200,
  parameter int          BPP        = 1,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic           HCLK,
  input  logic           HRESET,
  output logic [31:0]    HADDR,
  output logic [1:0]     HTRANS,
  output logic           HWRITE,
  output logic [2:0]     HSIZE,
  output logic [2:0]     HBURST,
  input  logic           HREADY,
  input  logic [31:0]    HRDATA,
  input  logic           HRESP,
  input  logic           start,
  output logic [BPP-1:0] pix_data,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic           pix_first,
  output logic           busy,
`ifdef AHB_PIXEL_READER_ERR_EN
  output logic           err,
`endif
  output logic           frame_done
);

  localparam int            CW   = $clog2(NUM_PIXELS + 1);
  localparam int            FCW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_PIXELS - 1);

  reader_state_t state_q, state_d;
  logic [CW-1:0] addr_cnt_q, addr_cnt_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic          out_q, out_d;
  logic          done_q, done_d;
  logic [FCW-1:0] fifo_cnt;
  logic [FCW:0]  used;
  logic          fifo_empty;
  logic          fifo_full;
  logic          credit_ok;
  logic          issue;
  logic          addr_fire;
  logic          data_fire;
  logic          pop;
  logic          start_ok;
  logic          last_pop;
  logic          err_hit;
  logic          unused_bits;

  assign unused_bits = ^{HRDATA, HRESP, fifo_full};

`ifdef AHB_PIXEL_READER_ERR_EN
  logic err_q, err_d;

  assign err_hit = out_q & HRESP;
  assign err     = err_q;

  always_comb begin
    err_d = err_q;
    if (start_ok)     err_d = 1'b0;
    else if (err_hit) err_d = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign err_hit = 1'b0;
`endif

  // Credits cover buffered pixels plus the one still in its data phase.
  assign used      = {1'b0, fifo_cnt} + (FCW + 1)'(out_q);
  assign credit_ok = used < (FCW + 1)'(FIFO_DEPTH);
  assign issue     = (state_q == S_FETCH) & credit_ok & ~err_hit;
  assign addr_fire = issue & HREADY;
  assign data_fire = out_q & HREADY & ~err_hit;
  assign pop       = pix_valid & pix_ready;
  assign start_ok  = start & (state_q == S_IDLE);
  assign last_pop  = pop & (pix_cnt_q == LAST) & (state_q == S_DRAIN);

  pixel_fifo #(
    .WIDTH (BPP),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .flush_i (err_hit),
    .push_i  (data_fire),
    .wdata_i (HRDATA[BPP-1:0]),
    .pop_i   (pop),
    .rdata_o (pix_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      addr_cnt_q <= '0;
      pix_cnt_q  <= '0;
      out_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      out_q      <= out_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_FETCH;
      S_FETCH: begin
        if (err_hit)                              state_d = S_IDLE;
        else if (addr_fire && addr_cnt_q == LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (err_hit || last_pop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_cnt_d = addr_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    out_d      = out_q;
    done_d     = last_pop & ~err_hit;
    if (start_ok) begin
      addr_cnt_d = '0;
      pix_cnt_d  = '0;
    end else begin
      if (addr_fire) addr_cnt_d = addr_cnt_q + CW'(1);
      if (pop)       pix_cnt_d  = pix_cnt_q + CW'(1);
    end
    if (err_hit)        out_d = 1'b0;
    else if (addr_fire) out_d = 1'b1;
    else if (data_fire) out_d = 1'b0;
  end

  always_comb begin
    HTRANS = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    busy   = (state_q != S_IDLE);
  end

  assign HADDR      = BASE_ADDR + (32'(addr_cnt_q) << 2);
  assign HWRITE     = 1'b0;
  assign HSIZE      = HSIZE_WORD;
  assign HBURST     = HBURST_SINGLE;
  assign pix_valid  = ~fifo_empty;
  assign pix_first  = pix_valid & (pix_cnt_q == '0);
  assign frame_done = done_q;

endmodule

// File: tb/tb_ahb_pixel_reader.sv
// Randomised bench for ahb_pixel_reader with an AHB slave and pixel scoreboard.
module tb_ahb_pixel_reader;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int NP  = 8;
  localparam int BPP = 8;
  localparam int FD  = 4;

  logic           HCLK = 1'b0;
  logic           HRESET;
  logic [31:0]    HADDR;
  logic [1:0]     HTRANS;
  logic           HWRITE;
  logic [2:0]     HSIZE;
  logic [2:0]     HBURST;
  logic           HREADY;
  logic [31:0]    HRDATA;
  logic           HRESP;
  logic           start;
  logic [BPP-1:0] pix_data;
  logic           pix_valid;
  logic           pix_ready;
  logic           pix_first;
  logic           busy;
  logic           frame_done;
`ifdef AHB_PIXEL_READER_ERR_EN
  logic           err;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int addr_n, acc_n, done_n, done_cyc, max_buf;
  int addr_cyc[$];
  int acc_cyc[$];
  logic [31:0] salt;
  logic [31:0] dp_addr;
  logic        dp_valid;
  logic        hold_chk;
  logic [31:0] hold_addr;

  ahb_pixel_reader #(
    .BASE_ADDR  (BASE),
    .NUM_PIXELS (NP),
    .BPP        (BPP),
    .FIFO_DEPTH (FD)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HREADY     (HREADY),
    .HRDATA     (HRDATA),
    .HRESP      (HRESP),
    .start      (start),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_first  (pix_first),
    .busy       (busy),
`ifdef AHB_PIXEL_READER_ERR_EN
    .err        (err),
`endif
    .frame_done (frame_done)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  assign HRDATA = word_at(dp_addr);

  // Slave: latch the address phase, return the word in the data phase.
  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_addr  <= '0;
    end else if (HREADY) begin
      dp_valid <= (HTRANS == 2'b10);
      dp_addr  <= HADDR;
    end
  end

  always @(negedge HCLK) begin
    logic [31:0] w;
    logic [31:0] ea;
    cyc++;
    if (HRESET) begin
      hold_chk = 1'b0;
    end else begin
      total++;
      if (HTRANS !== 2'b00 && HTRANS !== 2'b10) begin
        bad++;
        $display("FAIL htrans_legal got=%b", HTRANS);
      end
      if (hold_chk) begin
        total++;
        if (HTRANS !== 2'b10 || HADDR !== hold_addr) begin
          bad++;
          $display("FAIL hold_stable got=%b/%h exp=10/%h",
                   HTRANS, HADDR, hold_addr);
        end
      end
      hold_chk  = (HTRANS == 2'b10) && !HREADY;
      hold_addr = HADDR;
      total++;
      if (pix_first !== (pix_valid && acc_n == 0)) begin
        bad++;
        $display("FAIL pix_first got=%b valid=%b idx=%0d",
                 pix_first, pix_valid, acc_n);
      end
      if (HTRANS == 2'b10 && HREADY) begin
        ea = BASE + 32'(4 * addr_n);
        total++;
        if (HADDR !== ea || addr_n >= NP) begin
          bad++;
          $display("FAIL addr_seq n=%0d got=%h exp=%h", addr_n, HADDR, ea);
        end
        addr_cyc.push_back(cyc);
        addr_n++;
      end
      if (pix_valid && pix_ready) begin
        w = word_at(BASE + 32'(4 * acc_n));
        total++;
        if (pix_data !== w[BPP-1:0]) begin
          bad++;
          $display("FAIL pix_data idx=%0d got=%h exp=%h",
                   acc_n, pix_data, w[BPP-1:0]);
        end
        acc_cyc.push_back(cyc);
        acc_n++;
      end
      if (frame_done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (addr_n - acc_n > max_buf) max_buf = addr_n - acc_n;
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_sb();
    addr_n = 0;
    acc_n = 0;
    done_n = 0;
    done_cyc = -1;
    max_buf = 0;
    addr_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input int hr_pct,
                                input int pr_pct, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      HREADY    = ($urandom_range(99) < hr_pct);
      pix_ready = ($urandom_range(99) < pr_pct);
      @(negedge HCLK);
      if (frame_done) ok = 1'b1;
      tick();
    end
    HREADY    = 1'b1;
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    total += 6;
    if (HTRANS !== 2'b00) begin bad++; $display("FAIL rst_htrans got=%b exp=00", HTRANS); end
    if (HADDR !== BASE) begin bad++; $display("FAIL rst_haddr got=%h exp=%h", HADDR, BASE); end
    if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", pix_valid); end
    if (pix_first !== 1'b0) begin bad++; $display("FAIL rst_first got=%b exp=0", pix_first); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", frame_done); end
    total++;
    if ({HWRITE, HSIZE, HBURST} !== 7'b0_010_000) begin
      bad++;
      $display("FAIL rst_ties got=%b exp=0010000", {HWRITE, HSIZE, HBURST});
    end
    tick();
    HRESET = 1'b0;
    tick();
  endtask

  task automatic test_frame_basic();
    bit ok;
    clear_sb();
    pulse_start();
    run_until_done(60, 100, 100, ok);
    total += 4;
    if (!ok) begin bad++; $display("FAIL basic_timeout got=0 exp=1"); end
    if (addr_n != NP) begin bad++; $display("FAIL basic_addr_n got=%0d exp=%0d", addr_n, NP); end
    if (acc_n != NP) begin bad++; $display("FAIL basic_acc_n got=%0d exp=%0d", acc_n, NP); end
    if (done_n != 1) begin bad++; $display("FAIL basic_done_n got=%0d exp=1", done_n); end
    if (addr_n == NP && acc_n == NP) begin
      for (int k = 1; k < NP; k++) begin
        total++;
        if (addr_cyc[k] != addr_cyc[0] + k || acc_cyc[k] != acc_cyc[0] + k) begin
          bad++;
          $display("FAIL basic_rate k=%0d addr_cyc=%0d acc_cyc=%0d",
                   k, addr_cyc[k] - addr_cyc[0], acc_cyc[k] - acc_cyc[0]);
        end
      end
      total++;
      if (done_cyc != acc_cyc[NP-1] + 1) begin
        bad++;
        $display("FAIL basic_done_time got=%0d exp=%0d", done_cyc, acc_cyc[NP-1] + 1);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_wait_states();
    bit ok = 1'b0;
    bit did = 1'b0;
    int stalls = 0;
    int c;
    clear_sb();
    salt = $urandom;
    pulse_start();
    for (int i = 0; i < 60 && !ok; i++) begin
      if (stalls > 0) begin
        HREADY = 1'b0;
        stalls--;
      end else begin
        HREADY = 1'b1;
      end
      @(negedge HCLK);
      if (frame_done) ok = 1'b1;
      tick();
      if (!did && addr_n == 3) begin
        did = 1'b1;
        stalls = 3;
      end
    end
    HREADY = 1'b1;
    total += 2;
    if (!ok) begin bad++; $display("FAIL wait_timeout got=0 exp=1"); end
    if (acc_n != NP) begin bad++; $display("FAIL wait_acc_n got=%0d exp=%0d", acc_n, NP); end
    if (addr_n == NP && acc_n == NP) begin
      c = addr_cyc[2];
      total += 2;
      if (addr_cyc[3] != c + 4) begin
        bad++;
        $display("FAIL wait_addr3 got=%0d exp=%0d", addr_cyc[3] - c, 4);
      end
      if (acc_cyc[2] != c + 5) begin
        bad++;
        $display("FAIL wait_pix2 got=%0d exp=%0d", acc_cyc[2] - c, 5);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_sb();
    salt = $urandom;
    pix_ready = 1'b0;
    pulse_start();
    repeat (10) tick();
    @(negedge HCLK);
    total += 4;
    if (addr_n != FD) begin bad++; $display("FAIL bp_addr_n got=%0d exp=%0d", addr_n, FD); end
    if (HTRANS !== 2'b00) begin bad++; $display("FAIL bp_htrans got=%b exp=00", HTRANS); end
    if (pix_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", pix_valid); end
    if (acc_n != 0) begin bad++; $display("FAIL bp_acc_n got=%0d exp=0", acc_n); end
    tick();
    run_until_done(80, 100, 100, ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL bp_timeout got=0 exp=1"); end
    if (acc_n != NP) begin bad++; $display("FAIL bp_acc_total got=%0d exp=%0d", acc_n, NP); end
    if (max_buf > FD) begin bad++; $display("FAIL bp_max_buf got=%0d exp<=%0d", max_buf, FD); end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    clear_sb();
    salt = $urandom;
    pulse_start();
    for (int i = 0; i < 30 && acc_n < 3; i++) tick();
    HRESET = 1'b1;
    tick();
    @(negedge HCLK);
    total += 3;
    if (HTRANS !== 2'b00) begin bad++; $display("FAIL mid_rst_htrans got=%b exp=00", HTRANS); end
    if (pix_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", pix_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    tick();
    HRESET = 1'b0;
    tick();
    clear_sb();
    pulse_start();
    run_until_done(60, 100, 100, ok);
    total += 3;
    if (!ok) begin bad++; $display("FAIL mid_restart_timeout got=0 exp=1"); end
    if (acc_n != NP) begin bad++; $display("FAIL mid_restart_acc got=%0d exp=%0d", acc_n, NP); end
    if (done_n != 1) begin bad++; $display("FAIL mid_restart_done got=%0d exp=1", done_n); end
  endtask

  task automatic test_busy_start();
    bit ok;
    clear_sb();
    salt = $urandom;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    run_until_done(60, 100, 100, ok);
    repeat (4) tick();
    total += 4;
    if (!ok) begin bad++; $display("FAIL bstart_timeout got=0 exp=1"); end
    if (addr_n != NP) begin bad++; $display("FAIL bstart_addr_n got=%0d exp=%0d", addr_n, NP); end
    if (acc_n != NP) begin bad++; $display("FAIL bstart_acc_n got=%0d exp=%0d", acc_n, NP); end
    if (busy !== 1'b0) begin bad++; $display("FAIL bstart_busy got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    bit ok;
    for (int f = 0; f < 4; f++) begin
      clear_sb();
      salt = $urandom;
      HREADY = 1'b1;
      pulse_start();
      run_until_done(2000, 60 + 10 * f, 40 + 15 * f, ok);
      total += 5;
      if (!ok) begin bad++; $display("FAIL rnd_timeout f=%0d", f); end
      if (acc_n != NP) begin bad++; $display("FAIL rnd_acc f=%0d got=%0d exp=%0d", f, acc_n, NP); end
      if (addr_n != NP) begin bad++; $display("FAIL rnd_addr f=%0d got=%0d exp=%0d", f, addr_n, NP); end
      if (done_n != 1) begin bad++; $display("FAIL rnd_done f=%0d got=%0d exp=1", f, done_n); end
      if (max_buf > FD) begin bad++; $display("FAIL rnd_max_buf f=%0d got=%0d exp<=%0d", f, max_buf, FD); end
      if (acc_n == NP) begin
        total++;
        if (done_cyc != acc_cyc[NP-1] + 1) begin
          bad++;
          $display("FAIL rnd_done_time f=%0d got=%0d exp=%0d", f, done_cyc, acc_cyc[NP-1] + 1);
        end
      end
    end
  endtask

`ifdef AHB_PIXEL_READER_ERR_EN
  task automatic test_error();
    bit ok;
    int ph = 0;
    clear_sb();
    salt = $urandom;
    pulse_start();
    for (int i = 0; i < 40 && ph < 2; i++) begin
      if (ph == 0 && dp_valid && dp_addr == BASE + 32'd20) begin
        HRESP = 1'b1;
        HREADY = 1'b0;
        ph = 1;
        @(negedge HCLK);
        total++;
        if (HTRANS !== 2'b00) begin bad++; $display("FAIL err_htrans got=%b exp=00", HTRANS); end
      end else if (ph == 1) begin
        HRESP = 1'b1;
        HREADY = 1'b1;
        ph = 2;
      end
      tick();
    end
    HRESP = 1'b0;
    HREADY = 1'b1;
    @(negedge HCLK);
    total += 4;
    if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL err_busy got=%b exp=0", busy); end
    if (pix_valid !== 1'b0) begin bad++; $display("FAIL err_flush got=%b exp=0", pix_valid); end
    if (ph != 2) begin bad++; $display("FAIL err_inject got=%0d exp=2", ph); end
    repeat (5) tick();
    total += 2;
    if (done_n != 0) begin bad++; $display("FAIL err_no_done got=%0d exp=0", done_n); end
    if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
    clear_sb();
    pulse_start();
    @(negedge HCLK);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
    tick();
    run_until_done(60, 100, 100, ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL err_restart_timeout got=0 exp=1"); end
    if (acc_n != NP) begin bad++; $display("FAIL err_restart_acc got=%0d exp=%0d", acc_n, NP); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    HRESET = 1'b1;
    HREADY = 1'b1;
    HRESP = 1'b0;
    start = 1'b0;
    pix_ready = 1'b1;
    salt = $urandom;
    hold_chk = 1'b0;
    hold_addr = '0;
    clear_sb();
    test_reset();
    test_frame_basic();
    test_wait_states();
    test_backpressure();
    test_reset_mid();
    test_busy_start();
    test_random();
`ifdef AHB_PIXEL_READER_ERR_EN
    test_error();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
